bitnet_train_seq: RTL

- Training-step sequencer that drives one bitnet unit (e.g. unit3to3) through a complete forward/backward cycle per training sample.
- Accepts (input, target) samples over a valid/ready handshake and presents the input on fin. It pulses the forward phase, captures fout, forms the per-bit backward signal bin, runs the backward phase, then reports the result.
- Sits between the sample source (ROM/UART loader) and the unit array. It is the initiator end of the fd_prop/bk_prop protocol the units respond to.

---
 rtl/bitnet_train_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bitnet_train_seq.sv
// bitnet_train_seq: sequences one forward/backward training step per sample through a bitnet unit
module bitnet_train_seq #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int BK_CYCLES     = 4,
  parameter bit SKIP_CORRECT  = 1'b1,
  parameter int STAT_W        = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [WIDTH-1:0]           sample_x,
  input  logic [WIDTH-1:0]           sample_y,
  output logic                       fd_prop,
  output logic                       bk_prop,
  output logic [WIDTH-1:0]           fin,
  output logic [WIDTH-1:0]           bin,
  input  logic [WIDTH-1:0]           fout,
  input  logic                       control_out,
  output logic                       result_valid,
  output logic [WIDTH-1:0]           result_fout,
  output logic [$clog2(WIDTH+1)-1:0] result_errs,
  output logic                       result_ctrl,
  input  logic                       clear_stats,
  output logic [STAT_W-1:0]          stat_samples,
  output logic [STAT_W-1:0]          stat_errbits
);
  localparam int EW = $clog2(WIDTH + 1);
  localparam int MX = SETTLE_CYCLES > BK_CYCLES ? SETTLE_CYCLES : BK_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [STAT_W-1:0] SMAX = '1;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FWD     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] BWD     = 3'd3;
  localparam logic [2:0] REPORT  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] target_q, fout_q, diff;
  logic [EW-1:0]    errs;
  logic [STAT_W:0]  err_sum;
  logic             live, skip, to_report;

  assign diff         = target_q ^ fout_q;
  assign skip         = SKIP_CORRECT && errs == '0;
  assign to_report    = (state == CAPTURE && skip) || (state == BWD && cnt == '0);
  assign sample_ready = live && state == IDLE;
  assign fd_prop      = state == FWD;
  assign bk_prop      = state == BWD;
  assign bin          = (state == CAPTURE || state == BWD || state == REPORT) ? ~diff : '0;
  assign err_sum      = {1'b0, stat_errbits} + (STAT_W + 1)'(errs);

  // popcount of mismatched bits between target and captured output
  always_comb begin
    errs = '0;
    for (int i = 0; i < WIDTH; i++) errs = errs + EW'(diff[i]);
  end

  // phase sequencing; live keeps sample_ready low until the first edge out of reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      cnt      <= '0;
      live     <= 1'b0;
      fin      <= '0;
      target_q <= '0;
      fout_q   <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: if (sample_valid && sample_ready) begin
          fin      <= sample_x;
          target_q <= sample_y;
          cnt      <= CW'(SETTLE_CYCLES - 1);
          state    <= FWD;
        end
        FWD: if (cnt == '0) begin
          fout_q <= fout;
          state  <= CAPTURE;
        end else cnt <= cnt - CW'(1);
        CAPTURE: if (skip) state <= REPORT;
        else begin
          cnt   <= CW'(BK_CYCLES - 1);
          state <= BWD;
        end
        BWD: if (cnt == '0) state <= REPORT;
        else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // result registers load on the edge entering REPORT and hold until the next one
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      result_valid <= 1'b0;
      result_fout  <= '0;
      result_errs  <= '0;
      result_ctrl  <= 1'b0;
    end else begin
      result_valid <= to_report;
      if (to_report) begin
        result_fout <= fout_q;
        result_errs <= errs;
        result_ctrl <= control_out;
      end
    end
  end

  // saturating statistics; a clear coinciding with REPORT takes priority
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_samples <= '0;
      stat_errbits <= '0;
    end else if (clear_stats) begin
      stat_samples <= '0;
      stat_errbits <= '0;
    end else if (state == REPORT) begin
      stat_samples <= stat_samples == SMAX ? SMAX : stat_samples + STAT_W'(1);
      stat_errbits <= err_sum > {1'b0, SMAX} ? SMAX : err_sum[STAT_W-1:0];
    end
  end
endmodule
